parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : parking_gate_ctrl
//  Purpose  : Parking-lot gate controller. It counts free slots, asks for an
//             entry code, and opens the entry or exit barrier for a fixed
//             number of slow-clock ticks. Exit requests that arrive while the
//             controller is busy are latched and serviced once it is idle
//             again.
//  Ports    : CLK_IN        slow divided clock, rising edge
//             RST_N         asynchronous active-low reset
//             ENTRY_SENSOR  car present at the entry barrier
//             EXIT_SENSOR   car present at the exit barrier
//             PASS_IN[3:0]  entered code, qualified by PASS_VALID
//             PASS_VALID    one-cycle strobe for PASS_IN
//             GATE_IN_OPEN  entry barrier open (registered)
//             GATE_OUT_OPEN exit barrier open (registered)
//             FREE_SLOTS    free slot count (registered)
//             FULL          FREE_SLOTS == 0 (combinational)
//             ALARM         lockout alarm (registered)
//             STATE[2:0]    current FSM encoding (registered)
//  Config   : define PARKING_LOCKOUT_EN to send a visit with three wrong codes
//             to LOCKOUT with ALARM raised for 2*GATE_TICKS cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
   parameter int         CAPACITY   = 8,
   parameter logic [3:0] PASSWORD   = 4'hA,
   parameter int         GATE_TICKS = 30,
   parameter int         WAIT_TICKS = 50
) (
   input  logic       CLK_IN,
   input  logic       RST_N,
   input  logic       ENTRY_SENSOR,
   input  logic       EXIT_SENSOR,
   input  logic [3:0] PASS_IN,
   input  logic       PASS_VALID,
   output logic       GATE_IN_OPEN,
   output logic       GATE_OUT_OPEN,
   output logic [3:0] FREE_SLOTS,
   output logic       FULL,
   output logic       ALARM,
   output logic [2:0] STATE
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_PASS = 3'd1,
      S_GRANT     = 3'd2,
      S_EXIT_OPEN = 3'd3,
      S_LOCKOUT   = 3'd4
   } state_t;

   // One shared tick counter serves gate, password-timeout and lockout timing,
   // so it is sized for the longest of the three intervals.
   localparam int c_LOCK_TICKS = 2 * GATE_TICKS;
   localparam int c_TMR_MAX    = (WAIT_TICKS > c_LOCK_TICKS) ? WAIT_TICKS : c_LOCK_TICKS;
   localparam int c_TMR_W      = $clog2(c_TMR_MAX + 1);

   localparam logic [c_TMR_W-1:0] c_GATE_LAST = c_TMR_W'(GATE_TICKS - 1);
   localparam logic [c_TMR_W-1:0] c_WAIT_LAST = c_TMR_W'(WAIT_TICKS - 1);
`ifdef PARKING_LOCKOUT_EN
   localparam logic [c_TMR_W-1:0] c_LOCK_LAST = c_TMR_W'(c_LOCK_TICKS - 1);
`endif
   localparam logic [3:0]         c_CAPACITY  = 4'(CAPACITY);

   // Sensor edge detection
   logic r_primed;
   logic r_entry_s, r_entry_p;
   logic r_exit_s,  r_exit_p;
   logic w_entry_edge, w_exit_edge;

   // FSM state and registered outputs
   state_t             r_state;
   logic [c_TMR_W-1:0] r_tick;
   logic [1:0]         r_tries;
   logic               r_pending;
   logic [3:0]         r_free;
   logic               r_gate_in;
   logic               r_gate_out;
`ifdef PARKING_LOCKOUT_EN
   logic               r_alarm;
`endif

   logic w_full;
   logic w_code_ok;
   logic w_code_bad;

   // The first clock after reset loads both stages from the sensor, so a
   // sensor that is already high at reset release never looks like an edge.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_primed  <= 1'b0;
         r_entry_s <= 1'b0;
         r_entry_p <= 1'b0;
         r_exit_s  <= 1'b0;
         r_exit_p  <= 1'b0;
      end else begin
         r_primed  <= 1'b1;
         r_entry_s <= ENTRY_SENSOR;
         r_exit_s  <= EXIT_SENSOR;
         r_entry_p <= r_primed ? r_entry_s : ENTRY_SENSOR;
         r_exit_p  <= r_primed ? r_exit_s  : EXIT_SENSOR;
      end
   end

   assign w_entry_edge = r_entry_s & ~r_entry_p;
   assign w_exit_edge  = r_exit_s  & ~r_exit_p;

   assign w_full     = (r_free == 4'd0);
   assign w_code_ok  = PASS_VALID && (PASS_IN == PASSWORD);
   assign w_code_bad = PASS_VALID && (PASS_IN != PASSWORD);

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= S_IDLE;
         r_tick     <= '0;
         r_tries    <= 2'd0;
         r_pending  <= 1'b0;
         r_free     <= c_CAPACITY;
         r_gate_in  <= 1'b0;
         r_gate_out <= 1'b0;
`ifdef PARKING_LOCKOUT_EN
         r_alarm    <= 1'b0;
`endif
      end else begin
         // Exit requests while busy are remembered; IDLE overrides this below.
         if ((r_state != S_IDLE) && w_exit_edge) begin
            r_pending <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if ((w_exit_edge || r_pending) && (r_free < c_CAPACITY)) begin
                  r_state    <= S_EXIT_OPEN;
                  r_free     <= r_free + 4'd1;
                  r_pending  <= 1'b0;
                  r_gate_out <= 1'b1;
                  r_tick     <= '0;
               end else begin
                  // An exit request against an empty lot has nobody to let out.
                  r_pending <= 1'b0;
                  // A coinciding exit edge takes priority; the entry edge is lost.
                  if (w_entry_edge && !w_exit_edge && !w_full) begin
                     r_state <= S_WAIT_PASS;
                     r_tick  <= '0;
                     r_tries <= 2'd0;
                  end
               end
            end

            S_WAIT_PASS: begin
               if (w_code_ok) begin
                  r_state   <= S_GRANT;
                  r_free    <= r_free - 4'd1;
                  r_gate_in <= 1'b1;
                  r_tick    <= '0;
                  r_tries   <= 2'd0;
               end else if (w_code_bad) begin
                  r_tick <= '0;
`ifdef PARKING_LOCKOUT_EN
                  if (r_tries == 2'd2) begin
                     r_state <= S_LOCKOUT;
                     r_alarm <= 1'b1;
                     r_tries <= 2'd0;
                  end else begin
                     r_tries <= r_tries + 2'd1;
                  end
`else
                  // Saturate so the count never wraps during a long visit.
                  if (r_tries != 2'd3) begin
                     r_tries <= r_tries + 2'd1;
                  end
`endif
               end else if (r_tick == c_WAIT_LAST) begin
                  r_state <= S_IDLE;
                  r_tries <= 2'd0;
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end

            S_GRANT: begin
               if (r_tick == c_GATE_LAST) begin
                  r_state   <= S_IDLE;
                  r_gate_in <= 1'b0;
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end

            S_EXIT_OPEN: begin
               if (r_tick == c_GATE_LAST) begin
                  r_state    <= S_IDLE;
                  r_gate_out <= 1'b0;
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end

            S_LOCKOUT: begin
`ifdef PARKING_LOCKOUT_EN
               if (r_tick == c_LOCK_LAST) begin
                  r_state <= S_IDLE;
                  r_alarm <= 1'b0;
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
`else
               r_state <= S_IDLE;
`endif
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign STATE         = r_state;
   assign FREE_SLOTS    = r_free;
   assign FULL          = w_full;
   assign GATE_IN_OPEN  = r_gate_in;
   assign GATE_OUT_OPEN = r_gate_out;
`ifdef PARKING_LOCKOUT_EN
   assign ALARM         = r_alarm;
`else
   assign ALARM         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parking_gate_ctrl
//  Purpose  : Scoreboard bench for parking_gate_ctrl. Stimulus pushes the
//             expected result of every state transition (and of point-in-time
//             probes) into queues; a negedge monitor pops and compares them
//             whenever STATE changes or a probe is pending.
//  Config   : honours PARKING_LOCKOUT_EN for the wrong-code scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parking_gate_ctrl;

   localparam int         CAP = 8;
   localparam logic [3:0] PW  = 4'hA;
   localparam int         G   = 30;
   localparam int         W   = 50;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_GRNT = 3'd2;
   localparam logic [2:0] ST_EXIT = 3'd3;
   localparam logic [2:0] ST_LOCK = 3'd4;

   logic       clk;
   logic       RST_N;
   logic       ENTRY_SENSOR;
   logic       EXIT_SENSOR;
   logic [3:0] PASS_IN;
   logic       PASS_VALID;
   logic       GATE_IN_OPEN;
   logic       GATE_OUT_OPEN;
   logic [3:0] FREE_SLOTS;
   logic       FULL;
   logic       ALARM;
   logic [2:0] STATE;

   parking_gate_ctrl #(
      .CAPACITY   (CAP),
      .PASSWORD   (PW),
      .GATE_TICKS (G),
      .WAIT_TICKS (W)
   ) dut (
      .CLK_IN        (clk),
      .RST_N         (RST_N),
      .ENTRY_SENSOR  (ENTRY_SENSOR),
      .EXIT_SENSOR   (EXIT_SENSOR),
      .PASS_IN       (PASS_IN),
      .PASS_VALID    (PASS_VALID),
      .GATE_IN_OPEN  (GATE_IN_OPEN),
      .GATE_OUT_OPEN (GATE_OUT_OPEN),
      .FREE_SLOTS    (FREE_SLOTS),
      .FULL          (FULL),
      .ALARM         (ALARM),
      .STATE         (STATE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      int         free;
      bit         full;
      bit         gin;
      bit         gout;
      bit         alarm;
      int         dwell;   // cycles spent in the previous state, -1 = not checked
   } exp_t;

   exp_t q_trans[$];
   exp_t q_probe[$];

   int n_total = 0;
   int n_pass  = 0;
   int m_free  = CAP;

   task automatic chk(input string name, input int act, input int exp_v);
      n_total++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
   endtask

   task automatic push_t(input logic [2:0] st, input bit gin, input bit gout,
                         input bit alarm, input int dwell);
      exp_t e;
      e.st = st; e.free = m_free; e.full = (m_free == 0);
      e.gin = gin; e.gout = gout; e.alarm = alarm; e.dwell = dwell;
      q_trans.push_back(e);
   endtask

   task automatic push_p(input logic [2:0] st, input bit gin, input bit gout, input bit alarm);
      exp_t e;
      e.st = st; e.free = m_free; e.full = (m_free == 0);
      e.gin = gin; e.gout = gout; e.alarm = alarm; e.dwell = -1;
      q_probe.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic [2:0] r_last  = 3'd0;
   int         r_dwell = 0;
   int         r_tidx  = 0;
   int         r_pidx  = 0;

   task automatic cmp_outputs(input string tag, input exp_t e);
      chk({tag, "_state"}, int'(STATE),         int'(e.st));
      chk({tag, "_free"},  int'(FREE_SLOTS),    e.free);
      chk({tag, "_full"},  int'(FULL),          int'(e.full));
      chk({tag, "_gin"},   int'(GATE_IN_OPEN),  int'(e.gin));
      chk({tag, "_gout"},  int'(GATE_OUT_OPEN), int'(e.gout));
      chk({tag, "_alarm"}, int'(ALARM),         int'(e.alarm));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (STATE != r_last) begin
         if (q_trans.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_transition: state went %0d -> %0d, none expected",
                     r_last, STATE);
         end else begin
            e = q_trans.pop_front();
            cmp_outputs($sformatf("trans%0d", r_tidx), e);
            if (e.dwell >= 0)
               chk($sformatf("trans%0d_dwell", r_tidx), r_dwell, e.dwell);
         end
         r_tidx++;
         r_dwell = 1;
         r_last  = STATE;
      end else begin
         r_dwell++;
      end
      if (q_probe.size() != 0) begin
         e = q_probe.pop_front();
         cmp_outputs($sformatf("probe%0d", r_pidx), e);
         r_pidx++;
      end
      chk("gates_exclusive", int'(GATE_IN_OPEN & GATE_OUT_OPEN), 0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic entry_pulse();
      ENTRY_SENSOR = 1'b1; tick(1); ENTRY_SENSOR = 1'b0;
   endtask

   task automatic exit_pulse();
      EXIT_SENSOR = 1'b1; tick(1); EXIT_SENSOR = 1'b0;
   endtask

   task automatic strobe(input logic [3:0] code);
      PASS_IN = code; PASS_VALID = 1'b1; tick(1);
      PASS_VALID = 1'b0; PASS_IN = 4'h0;
   endtask

   task automatic do_entry();
      push_t(ST_WAIT, 1'b0, 1'b0, 1'b0, -1);
      m_free--;
      push_t(ST_GRNT, 1'b1, 1'b0, 1'b0, 1);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, G);
      entry_pulse(); tick(1); strobe(PW); tick(G + 3);
   endtask

   task automatic do_exit();
      m_free++;
      push_t(ST_EXIT, 1'b0, 1'b1, 1'b0, -1);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, G);
      exit_pulse(); tick(G + 4);
   endtask

   task automatic do_reset();
      RST_N = 1'b0; m_free = CAP; tick(2);
      RST_N = 1'b1; tick(3);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   // ---------------- scenario ----------------
   initial begin
      RST_N = 1'b1; ENTRY_SENSOR = 1'b0; EXIT_SENSOR = 1'b0;
      PASS_IN = 4'h0; PASS_VALID = 1'b0;
      #2 RST_N = 1'b0;
      push_p(ST_IDLE, 1'b0, 1'b0, 1'b0);          // reset values
      tick(3);
      RST_N = 1'b1;
      tick(3);

      // Fill the lot with eight granted entries.
      for (int i = 0; i < CAP; i++) do_entry();

      // Entry edge while full is ignored.
      entry_pulse(); tick(4);
      push_p(ST_IDLE, 1'b0, 1'b0, 1'b0);
      tick(2);

      // One car leaves.
      do_exit();

      // Exit edge with an empty lot is ignored.
      do_reset();
      push_p(ST_IDLE, 1'b0, 1'b0, 1'b0);
      tick(1);
      exit_pulse(); tick(4);
      push_p(ST_IDLE, 1'b0, 1'b0, 1'b0);
      tick(2);

      // Three parked, then simultaneous entry and exit: exit wins.
      for (int i = 0; i < 3; i++) do_entry();
      m_free++;
      push_t(ST_EXIT, 1'b0, 1'b1, 1'b0, -1);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, G);
      ENTRY_SENSOR = 1'b1; EXIT_SENSOR = 1'b1; tick(1);
      ENTRY_SENSOR = 1'b0; EXIT_SENSOR = 1'b0;
      tick(G + 6);
      push_p(ST_IDLE, 1'b0, 1'b0, 1'b0);
      tick(2);

      // Exit edge during GRANT is latched and served one cycle after GRANT.
      push_t(ST_WAIT, 1'b0, 1'b0, 1'b0, -1);
      m_free--;
      push_t(ST_GRNT, 1'b1, 1'b0, 1'b0, 1);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, G);
      m_free++;
      push_t(ST_EXIT, 1'b0, 1'b1, 1'b0, 1);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, G);
      entry_pulse(); tick(1); strobe(PW); tick(5);
      exit_pulse(); tick(2 * G + 10);

      // Password timeout with no strobe.
      push_t(ST_WAIT, 1'b0, 1'b0, 1'b0, -1);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, W);
      entry_pulse(); tick(W + 5);

      // Three wrong codes in one visit.
      push_t(ST_WAIT, 1'b0, 1'b0, 1'b0, -1);
`ifdef PARKING_LOCKOUT_EN
      push_t(ST_LOCK, 1'b0, 1'b0, 1'b1, 7);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, 2 * G);
`else
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, 7 + W);
`endif
      entry_pulse(); tick(1);
      strobe(4'h5); tick(2);
      strobe(4'h0); tick(2);
      strobe(4'hF);
`ifdef PARKING_LOCKOUT_EN
      tick(2 * G + 4);
`else
      tick(2);
      push_p(ST_WAIT, 1'b0, 1'b0, 1'b0);
      tick(W + 2);
`endif

      // Two wrong codes followed by the right one still grants entry.
      push_t(ST_WAIT, 1'b0, 1'b0, 1'b0, -1);
      m_free--;
      push_t(ST_GRNT, 1'b1, 1'b0, 1'b0, 3);
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, G);
      entry_pulse(); tick(1);
      strobe(4'h3); strobe(4'h9); strobe(PW);
      tick(G + 4);

      // Reset in the middle of GRANT closes the gate and empties the lot.
      push_t(ST_WAIT, 1'b0, 1'b0, 1'b0, -1);
      m_free--;
      push_t(ST_GRNT, 1'b1, 1'b0, 1'b0, 1);
      entry_pulse(); tick(1); strobe(PW); tick(10);
      m_free = CAP;
      push_t(ST_IDLE, 1'b0, 1'b0, 1'b0, -1);
      #2 RST_N = 1'b0;

      // Sensors held high across reset release produce no edge.
      ENTRY_SENSOR = 1'b1; EXIT_SENSOR = 1'b1;
      tick(3);
      RST_N = 1'b1;
      tick(6);
      push_p(ST_IDLE, 1'b0, 1'b0, 1'b0);
      tick(1);
      ENTRY_SENSOR = 1'b0; EXIT_SENSOR = 1'b0;
      tick(4);
      push_p(ST_IDLE, 1'b0, 1'b0, 1'b0);
      tick(3);

      chk("trans_queue_drained", q_trans.size(), 0);
      chk("probe_queue_drained", q_probe.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
